// File: rtl/sram_buffer_ctrl.sv
// sram_buffer_ctrl: arbitrates one single-port row buffer between a row-write
// port and a burst-read engine. Read data returns one cycle after issue and is
// absorbed by a 2-entry FIFO, so bursts stream at one row per cycle under
// valid/ready backpressure.
// Optional macro BUF_RR_ARB_EN: round-robin write/read arbitration instead of
// fixed read priority.
module sram_buffer_ctrl #(
    parameter int ARR_WIDTH  = 16,
    parameter int ADDR_DEPTH = 128,
    parameter int AW         = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [AW-1:0]          wr_addr,
    input  logic [ARR_WIDTH*8-1:0] wr_data,
    input  logic                   rd_start,
    input  logic [AW-1:0]          rd_base,
    input  logic [7:0]             rd_len,
    output logic                   rd_busy,
    output logic [ARR_WIDTH*8-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   rd_last,
    input  logic                   rd_ready,
    output logic                   buf_enable,
    output logic                   buf_wr_en,
    output logic [AW-1:0]          buf_addr,
    output logic [ARR_WIDTH*8-1:0] buf_wdata,
    input  logic [ARR_WIDTH*8-1:0] buf_rdata
);
    localparam int DW = ARR_WIDTH * 8;
    localparam logic [AW-1:0] ADDR_MASK = AW'(ADDR_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } fifo_ent_t;

    state_t    state, state_nxt;
    logic [AW-1:0] base;
    logic [7:0]    len, issued;
    logic          inflight_vld, inflight_last;
    fifo_ent_t     fifo_mem [2];
    logic          wr_ptr, rd_ptr;
    logic [1:0]    fifo_cnt;

    logic pop, credit_ok, rd_elig, wr_req, issue_last;
    logic rd_grant, wr_grant;

    assign rd_valid   = (fifo_cnt != 2'd0);
    assign rd_data    = fifo_mem[rd_ptr].data;
    assign rd_last    = rd_valid & fifo_mem[rd_ptr].last;
    assign pop        = rd_valid & rd_ready;
    assign rd_busy    = (state != IDLE);
    assign issue_last = (issued == len - 8'd1);

    // A read may issue only if the FIFO can hold it once it lands:
    // fifo_cnt + inflight - pop < 2, rearranged to avoid underflow.
    assign credit_ok = ({1'b0, fifo_cnt} + {2'b0, inflight_vld}) < (3'd2 + {2'b0, pop});
    assign rd_elig   = (state == BURST) & credit_ok;
    // Writes are blocked while reset is asserted so the buffer stays idle.
    assign wr_req    = wr_valid & reset_n;

`ifdef BUF_RR_ARB_EN
    logic rr_wr_pri;

    // Round-robin pointer: whoever was granted last yields next time; write first after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      rr_wr_pri <= 1'b1;
        else if (wr_grant) rr_wr_pri <= 1'b0;
        else if (rd_grant) rr_wr_pri <= 1'b1;
    end

    // Grant: alternate when both sides want the port.
    always_comb begin
        rd_grant = rd_elig;
        wr_grant = wr_req;
        if (rd_elig && wr_req) begin
            wr_grant = rr_wr_pri;
            rd_grant = ~rr_wr_pri;
        end
    end
`else
    // Grant: an eligible burst read always wins; writes wait for a free cycle.
    always_comb begin
        rd_grant = rd_elig;
        wr_grant = wr_req & ~rd_elig;
    end
`endif

    assign wr_ready = wr_grant;

    // Buffer port drive: read, write or idle (active-low strobes).
    always_comb begin
        buf_enable = 1'b1;
        buf_wr_en  = 1'b1;
        buf_addr   = '0;
        buf_wdata  = '0;
        if (rd_grant) begin
            buf_enable = 1'b0;
            buf_addr   = (base + issued[AW-1:0]) & ADDR_MASK;
        end else if (wr_grant) begin
            buf_enable = 1'b0;
            buf_wr_en  = 1'b0;
            buf_addr   = wr_addr;
            buf_wdata  = wr_data;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // FSM next state: start burst, finish issuing, wait for last beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_start && rd_len != 8'd0) state_nxt = BURST;
            BURST:   if (rd_grant && issue_last)     state_nxt = DRAIN;
            DRAIN:   if (pop && rd_last)             state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Burst descriptor latch and issue counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base   <= '0;
            len    <= '0;
            issued <= '0;
        end else if (state == IDLE && rd_start && rd_len != 8'd0) begin
            base   <= rd_base;
            len    <= rd_len;
            issued <= '0;
        end else if (rd_grant) begin
            issued <= issued + 8'd1;
        end
    end

    // Track the read whose data appears on buf_rdata next cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_vld  <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight_vld  <= rd_grant;
            inflight_last <= rd_grant & issue_last;
        end
    end

    // Output FIFO: push returning row, pop on accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (inflight_vld) begin
                fifo_mem[wr_ptr] <= '{last: inflight_last, data: buf_rdata};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, inflight_vld} - {1'b0, pop};
        end
    end

endmodule

// File: tb/tb_sram_buffer_ctrl.sv
// Testbench for sram_buffer_ctrl: behavioural row-buffer model plus a
// reference memory and expected-beat queues built from the burst parameters.
module tb_sram_buffer_ctrl;
    localparam int W  = 16;
    localparam int D  = 128;
    localparam int AW = 7;
    localparam int DW = W * 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_start, rd_busy, rd_valid, rd_last, rd_ready;
    logic [AW-1:0] rd_base;
    logic [7:0]    rd_len;
    logic [DW-1:0] rd_data;
    logic          buf_enable, buf_wr_en;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_wdata, buf_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] sram    [D];
    logic [DW-1:0] ref_mem [D];
    logic [DW-1:0] sram_q;

    always #5 clk = ~clk;

    sram_buffer_ctrl #(.ARR_WIDTH(W), .ADDR_DEPTH(D), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .buf_enable(buf_enable), .buf_wr_en(buf_wr_en), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata)
    );

    // Single-port buffer model with 1-cycle read latency.
    always @(posedge clk) begin
        if (!buf_enable) begin
            if (!buf_wr_en) sram[buf_addr] <= buf_wdata;
            else            sram_q <= sram[buf_addr];
        end
    end
    assign buf_rdata = sram_q;

    function automatic logic [DW-1:0] rnd_row();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Single row write while idle; starts and ends just after a rising edge.
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit with_rd0);
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        rd_start = with_rd0; rd_len = 8'd0; rd_base = 7'd3;
        @(negedge clk);
        n_chk++;
        if (wr_ready !== 1'b1 || buf_enable !== 1'b0 || buf_wr_en !== 1'b0 ||
            buf_addr !== a || buf_wdata !== d) begin
            n_fail++;
            $display("FAIL write_grant: got rdy=%b en=%b we=%b addr=%0d data=%h, need rdy=1 en=0 we=0 addr=%0d data=%h",
                     wr_ready, buf_enable, buf_wr_en, buf_addr, buf_wdata, a, d);
        end
        ref_mem[a] = d;
        @(posedge clk); #1;
        wr_valid = 1'b0; rd_start = 1'b0;
        if (with_rd0) begin
            n_chk++;
            if (rd_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL len0_ignored: rd_busy=%b, need 0", rd_busy);
            end
        end
    endtask

    // Run one burst to completion, scoring every issue, grant and beat.
    // mode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
    task automatic burst_scenario(input logic [AW-1:0] base, input logic [7:0] len,
                                  input int mode, input bit wr_hold, input bit chk_lat);
        logic [DW-1:0] exp_q[$];
        logic [AW-1:0] addr_q[$];
        logic [AW-1:0] a, wrow;
        logic [DW-1:0] exp_d, prev_data, wdat;
        int c, issues, accepted, first_v, last_c;
        bit done, prev_valid, prev_ready;
        string grants, want;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            exp_q.push_back(ref_mem[a]);
            addr_q.push_back(a);
        end
        rd_start = 1'b1; rd_base = base; rd_len = len; rd_ready = 1'b1;
        wrow = 7'd64; wdat = rnd_row();
        c = 0; issues = 0; accepted = 0; first_v = -1; last_c = -1;
        done = 0; prev_valid = 0; prev_ready = 0; prev_data = '0; grants = "";
        @(posedge clk);
        while (!done && c < 300) begin
            #1; c++;
            rd_start = 1'b0;
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (wr_hold) begin wr_valid = 1'b1; wr_addr = wrow; wr_data = wdat; end
            @(negedge clk);
            n_chk++;
            if (rd_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_during_burst: cycle %0d rd_busy=%b, need 1", c, rd_busy);
            end
            n_chk++;
            if (issues - accepted > 2) begin
                n_fail++;
                $display("FAIL occupancy: %0d rows outstanding, need at most 2", issues - accepted);
            end
            if (prev_valid && !prev_ready) begin
                n_chk++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL stall_hold: valid=%b data=%h, need valid=1 data=%h", rd_valid, rd_data, prev_data);
                end
            end
            if (buf_enable === 1'b0 && buf_wr_en === 1'b1) begin
                grants = {grants, "R"};
                n_chk++;
                if (addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_issue: read at %0d, need no more reads", buf_addr);
                end else begin
                    a = addr_q.pop_front();
                    if (buf_addr !== a || wr_ready !== 1'b0) begin
                        n_fail++;
                        $display("FAIL issue_addr: addr=%0d wr_ready=%b, need addr=%0d wr_ready=0", buf_addr, wr_ready, a);
                    end
                end
                issues++;
            end
            if (wr_ready === 1'b1) begin
                grants = {grants, "W"};
                n_chk++;
                if (buf_enable !== 1'b0 || buf_wr_en !== 1'b0 || buf_addr !== wrow || buf_wdata !== wdat) begin
                    n_fail++;
                    $display("FAIL contention_write: en=%b we=%b addr=%0d, need en=0 we=0 addr=%0d", buf_enable, buf_wr_en, buf_addr, wrow);
                end
                ref_mem[wrow] = wdat;
                wrow = wrow + 7'd1;
                wdat = rnd_row();
            end
            if (rd_valid === 1'b1 && first_v < 0) first_v = c;
            if (rd_valid === 1'b1 && rd_ready) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_beat: data=%h, need no beat", rd_data);
                end else begin
                    exp_d = exp_q.pop_front();
                    if (rd_data !== exp_d || rd_last !== (exp_q.size() == 0)) begin
                        n_fail++;
                        $display("FAIL beat_%0d: data=%h last=%b, need data=%h last=%b",
                                 accepted, rd_data, rd_last, exp_d, exp_q.size() == 0);
                    end
                end
                accepted++;
                if (exp_q.size() == 0) begin done = 1; last_c = c; end
            end
            prev_valid = rd_valid; prev_ready = rd_ready; prev_data = rd_data;
            @(posedge clk);
        end
        #1;
        wr_valid = 1'b0; rd_ready = 1'b1;
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL burst_timeout: %0d of %0d beats, need all", accepted, len);
        end
        n_chk++;
        if (rd_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_drop: rd_busy=%b after last beat, need 0", rd_busy);
        end
        if (chk_lat) begin
            n_chk++;
            if (first_v != 3 || last_c != 2 + int'(len)) begin
                n_fail++;
                $display("FAIL latency: first valid k+%0d last k+%0d, need k+3 and k+%0d", first_v, last_c, 2 + int'(len));
            end
        end
        if (wr_hold) begin
            want = "";
`ifdef BUF_RR_ARB_EN
            for (int i = 0; i < int'(len); i++) want = {want, "WR"};
            n_chk++;
            if (grants.len() < want.len() || grants.substr(0, want.len() - 1) != want) begin
                n_fail++;
                $display("FAIL rr_grant_order: got %s, need prefix %s", grants, want);
            end
`else
            for (int i = 0; i < int'(len); i++) want = {want, "R"};
            want = {want, "W"};
            n_chk++;
            if (grants.len() < want.len() || grants.substr(0, want.len() - 1) != want) begin
                n_fail++;
                $display("FAIL fixed_grant_order: got %s, need prefix %s", grants, want);
            end
`endif
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_valid = 1'b0; rd_start = 1'b0; rd_len = 8'd0; rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        wr_valid = 1'b1; wr_addr = 7'd9; wr_data = rnd_row();
        rd_start = 1'b1; rd_base = 7'd0; rd_len = 8'd5; rd_ready = 1'b1;
        #3;
        n_chk++;
        if (rd_busy !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== '0) begin
            n_fail++;
            $display("FAIL reset_rd: busy=%b valid=%b last=%b data=%h, need all 0", rd_busy, rd_valid, rd_last, rd_data);
        end
        n_chk++;
        if (buf_enable !== 1'b1 || buf_wr_en !== 1'b1 || buf_addr !== '0 || buf_wdata !== '0 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_buf: en=%b we=%b addr=%0d wdata=%h wr_ready=%b, need 1 1 0 0 0",
                     buf_enable, buf_wr_en, buf_addr, buf_wdata, wr_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (rd_busy !== 1'b0 || buf_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b en=%b, need 0 1", rd_busy, buf_enable);
        end
        wr_valid = 1'b0; rd_start = 1'b0; rd_len = 8'd0;
        reset_n = 1'b1;
    endtask

    task automatic test_writes();
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = 8'(8'h11 * (i + 1));
            do_write(AW'(i), {W{b}}, 1'b1);
        end
    endtask

    task automatic test_burst();
        burst_scenario(7'd0, 8'd4, 0, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        do_write(7'd126, rnd_row(), 1'b0);
        do_write(7'd127, rnd_row(), 1'b0);
        burst_scenario(7'd126, 8'd4, 0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        for (int i = 4; i < 8; i++) do_write(AW'(i), rnd_row(), 1'b0);
        burst_scenario(7'd0, 8'd8, 1, 1'b0, 1'b0);
    endtask

    task automatic test_contention();
        do_reset();
`ifdef BUF_RR_ARB_EN
        burst_scenario(7'd0, 8'd8, 0, 1'b1, 1'b0);
`else
        burst_scenario(7'd0, 8'd8, 0, 1'b1, 1'b1);
`endif
    endtask

    task automatic test_reset_mid_burst();
        int c, acc;
        bit hit;
        rd_start = 1'b1; rd_base = 7'd0; rd_len = 8'd10; rd_ready = 1'b1;
        c = 0; acc = 0; hit = 0;
        @(posedge clk);
        while (!hit && c < 100) begin
            #1; c++; rd_start = 1'b0;
            @(negedge clk);
            if (rd_valid === 1'b1 && acc == 2) hit = 1;
            else begin
                if (rd_valid === 1'b1) begin
                    n_chk++;
                    if (rd_data !== ref_mem[acc]) begin
                        n_fail++;
                        $display("FAIL pre_reset_beat_%0d: data=%h, need %h", acc, rd_data, ref_mem[acc]);
                    end
                    acc++;
                end
                @(posedge clk);
            end
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL mid_burst_timeout: %0d beats seen, need third beat", acc);
        end
        reset_n = 1'b0;
        #1;
        n_chk++;
        if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || buf_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_burst: valid=%b busy=%b en=%b, need 0 0 1", rd_valid, rd_busy, buf_enable);
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (rd_valid !== 1'b0 || rd_busy !== 1'b0 || buf_enable !== 1'b1) begin
                n_fail++;
                $display("FAIL post_reset_quiet: valid=%b busy=%b en=%b, need 0 0 1", rd_valid, rd_busy, buf_enable);
            end
        end
        @(posedge clk); #1;
        burst_scenario(7'd5, 8'd3, 0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [AW-1:0] b;
        logic [7:0]    l;
        for (int it = 0; it < 6; it++) begin
            for (int j = 0; j < 3; j++) do_write(AW'($urandom_range(0, D - 1)), rnd_row(), 1'b0);
            b = AW'($urandom_range(0, D - 1));
            l = 8'($urandom_range(1, 20));
            burst_scenario(b, l, 2, 1'b0, 1'b0);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin sram[i] = '0; ref_mem[i] = '0; end
        sram_q = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_start = 1'b0; rd_base = '0; rd_len = '0; rd_ready = 1'b1;
        test_reset();
        test_writes();
        test_burst();
        test_wrap();
        test_backpressure();
        test_contention();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_buffer_ctrl.md
Name: sram_buffer_ctrl

Overview:
- Sequencing and arbitration controller in front of one single-port sram_matrix_buffer_wide instance (ARR_WIDTH lanes x 8 bit, ADDR_DEPTH rows).
- Shares the buffer between a row-write port (loader side) and a burst-read engine (compute side).
- The burst-read engine streams rows out through a valid/ready interface with backpressure.
- Absorbs the buffer's 1-cycle read latency with a 2-entry output FIFO, so reads sustain one row per cycle.

Parameters:
- ARR_WIDTH, 16, number of 8-bit lanes per row.
- ADDR_DEPTH, 128, rows in buffer (power of two).
- AW, 7, address width = log2(ADDR_DEPTH).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  row-write request.
- wr_ready  out  1  row write accepted this cycle when wr_valid & wr_ready.
- wr_addr  in  AW  write row address.
- wr_data  in  ARR_WIDTH*8  write row data.
- rd_start  in  1  burst-read command strobe.
- rd_base  in  AW  first row of burst.
- rd_len  in  8  burst length in rows, 1..255; 0 = no-op.
- rd_busy  out  1  burst in progress.
- rd_data  out  ARR_WIDTH*8  streamed row.
- rd_valid  out  1  rd_data valid.
- rd_last  out  1  final row of burst, qualified by rd_valid.
- rd_ready  in  1  downstream accepts the beat.
- buf_enable  out  1  buffer enable, active-low.
- buf_wr_en  out  1  buffer write enable, active-low.
- buf_addr  out  AW  buffer address.
- buf_wdata  out  ARR_WIDTH*8  buffer write data.
- buf_rdata  in  ARR_WIDTH*8  buffer read data, valid the cycle after the read is issued.

Behaviour:
- Reset values (async): rd_busy=0, rd_valid=0, rd_last=0, rd_data=0, buf_enable=1, buf_wr_en=1, buf_addr=0, buf_wdata=0; FIFO empty, all counters 0, FSM=IDLE.
- FSM IDLE:
  - rd_start with rd_len!=0 latches base and len, clears the issue counter, goes to BURST, rd_busy=1 from the next cycle.
  - rd_start with rd_len=0 is ignored; no state change.
- FSM BURST:
  - Issues one read per granted cycle at (base + issued) mod ADDR_DEPTH; the address wraps 127 -> 0.
  - After issuing len reads, goes to DRAIN.
- FSM DRAIN:
  - Waits until the last beat is accepted (rd_valid & rd_ready & rd_last), then goes to IDLE.
  - rd_busy drops the cycle after that acceptance.
- rd_start while rd_busy=1 is ignored.
- Issue credit: a read may issue only if fifo_count + inflight - pop < 2, where pop = rd_valid & rd_ready.
  - Guarantees no overflow.
  - Sustains 1 row/cycle with rd_ready held high.
- Read issue cycle N: buf_enable=0, buf_wr_en=1, buf_addr driven. buf_rdata is pushed into the FIFO at the end of N+1; rd_valid is high at N+2.
- Latency: rd_start sampled at edge k -> first issue in cycle k+1 -> first rd_valid in cycle k+3.
- rd_last marks the FIFO entry tagged as the len-th row.
- rd_data/rd_valid come from the FIFO head and must remain stable while rd_valid=1 and rd_ready=0.
- Write: when granted, drive buf_enable=0, buf_wr_en=0, buf_addr=wr_addr, buf_wdata=wr_data for that cycle; wr_ready=1 in exactly the granted cycle.
- Arbitration (default): a pending, credit-eligible burst read has fixed priority over writes. wr_ready=0 in any cycle a read issues.
- Idle cycle (no grant): buf_enable=1, buf_wr_en=1.
- Ordering: a write granted before a read to the same row is returned by that read; the single port serialises all accesses.
- Reset asserted mid-burst: FIFO flushed, in-flight read discarded, no beats emitted after reset release.

Optional Feature:
- Macro: BUF_RR_ARB_EN.
- Defined: round-robin between write and read when both are eligible in the same cycle; the grant alternates starting with write after reset. Sustained concurrent traffic yields 1 write : 1 read.
- Undefined: read fixed priority as above; writes starve while a burst is issuing.

Test Plan:
- Reset then 4 writes rows 0..3 with data 0x11..0x44 (all lanes) and rd_len=0 -> wr_ready=1 each cycle, buffer written with buf_enable=0, buf_wr_en=0; rd_start ignored, rd_busy stays 0.
- Burst rd_base=0, rd_len=4, rd_ready=1 -> rd_valid cycles k+3..k+6 with rows 0x11,0x22,0x33,0x44; rd_last only on 0x44; rd_busy low at k+7.
- Wrap: rd_base=126, rd_len=4 -> addresses 126,127,0,1 in order; data matches prior writes.
- Backpressure: rd_len=8, rd_ready toggles 1,0,0,1 -> no beat lost or duplicated, data held stable while stalled, at most 2 buffered, all 8 delivered in order.
- Contention: wr_valid held high during an 8-row burst -> without macro, wr_ready=0 until issues finish then 1; with BUF_RR_ARB_EN, the grant alternates W,R,W,R.
- reset_n pulsed low at the 3rd beat of a 10-row burst -> rd_valid=0, rd_busy=0 immediately; no beats after release; a new burst works.
